// File: rtl/pdu_dbus_bridge_pkg.sv
// ----------------------------------------------------------------------------
// pdu_bus_pkg
// Shared definitions for the PDU data-bus bridge:
//   - pdu_state_t        : bridge FSM states (IDLE / ACCESS / RESP)
//   - PDU_DBUS_DEF_BASE  : default packed base addresses for three slaves
//   - PDU_DBUS_DEF_MASK  : default packed match masks for three slaves
//   - pdu_idx_w()        : width of a slave index for a given slave count
// ----------------------------------------------------------------------------
package pdu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } pdu_state_t;

    // Slave 0 is the rightmost 32-bit field.
    localparam logic [3*32-1:0] PDU_DBUS_DEF_BASE = {32'h0000_8100, 32'h0000_8000, 32'h0000_4000};
    localparam logic [3*32-1:0] PDU_DBUS_DEF_MASK = {32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_C000};

    // A single-slave build still needs a 1-bit index signal.
    function automatic int unsigned pdu_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pdu_dbus_bridge_if.sv
// ----------------------------------------------------------------------------
// pdu_dbus_bridge_if
// Host-side and slave-side signals of the PDU data-bus bridge.
//   modport slave  : the bridge's view (takes host requests, drives slaves)
//   modport master : the environment's view (host plus slave devices)
// Signals:
//   h_req, h_we, h_addr, h_wdata      host request
//   h_busy, h_ack, h_err, h_rdata     host response
//   s_sel, s_we, s_addr, s_wdata      slave access (one-hot select)
//   s_ready, s_rdata                  per-slave completion and read data
// ----------------------------------------------------------------------------
interface pdu_dbus_bridge_if #(
    parameter int unsigned N_SLV  = 3,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    logic                    h_req;
    logic                    h_we;
    logic [ADDR_W-1:0]       h_addr;
    logic [DATA_W-1:0]       h_wdata;
    logic                    h_busy;
    logic                    h_ack;
    logic                    h_err;
    logic [DATA_W-1:0]       h_rdata;
    logic [N_SLV-1:0]        s_sel;
    logic                    s_we;
    logic [ADDR_W-1:0]       s_addr;
    logic [DATA_W-1:0]       s_wdata;
    logic [N_SLV-1:0]        s_ready;
    logic [N_SLV*DATA_W-1:0] s_rdata;

    modport slave (
        input  h_req, h_we, h_addr, h_wdata, s_ready, s_rdata,
        output h_busy, h_ack, h_err, h_rdata, s_sel, s_we, s_addr, s_wdata
    );

    modport master (
        output h_req, h_we, h_addr, h_wdata, s_ready, s_rdata,
        input  h_busy, h_ack, h_err, h_rdata, s_sel, s_we, s_addr, s_wdata
    );

endinterface

// File: rtl/pdu_dbus_bridge_decode.sv
// ----------------------------------------------------------------------------
// pdu_dbus_decode
// Address decoder: slave k hits when (addr & mask[k]) == base[k]; the lowest
// hitting index wins.
// Ports:
//   addr  in   ADDR_W  host byte address
//   hit   out  1       some slave matched
//   idx   out  IDX_W   index of the winning slave (0 when no hit)
// ----------------------------------------------------------------------------
module pdu_dbus_decode
    import pdu_bus_pkg::*;
#(
    parameter int unsigned                N_SLV    = 3,
    parameter int unsigned                ADDR_W   = 32,
    parameter logic [N_SLV*ADDR_W-1:0]    SLV_BASE = PDU_DBUS_DEF_BASE,
    parameter logic [N_SLV*ADDR_W-1:0]    SLV_MASK = PDU_DBUS_DEF_MASK,
    localparam int unsigned               IDX_W    = pdu_idx_w(N_SLV)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        // Ascending scan; the first match locks out later indices.
        for (int unsigned k = 0; k < N_SLV; k++) begin
            if (!hit && ((addr & SLV_MASK[k*ADDR_W +: ADDR_W]) == SLV_BASE[k*ADDR_W +: ADDR_W])) begin
                hit = 1'b1;
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/pdu_dbus_bridge.sv
// ----------------------------------------------------------------------------
// pdu_dbus_bridge
// Single-outstanding bridge from a host request port to N_SLV memory-mapped
// slaves. A request in IDLE is decoded and latched; a hit enters ACCESS and
// holds the slave access until the selected slave's s_ready, a miss goes
// straight to RESP with an error. RESP pulses h_ack for one cycle.
// Ports:
//   clk   in  single clock, rising edge
//   rstn  in  asynchronous active-low reset
//   bus   pdu_dbus_bridge_if.slave (host and slave signal bundle)
// Build option:
//   PDU_DBUS_TIMEOUT_EN  when defined, ACCESS ends with an error after
//                        TIMEOUT_CYC cycles without s_ready; otherwise ACCESS
//                        waits indefinitely.
// ----------------------------------------------------------------------------
module pdu_dbus_bridge
    import pdu_bus_pkg::*;
#(
    parameter int unsigned             N_SLV       = 3,
    parameter int unsigned             ADDR_W      = 32,
    parameter int unsigned             DATA_W      = 32,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE    = PDU_DBUS_DEF_BASE,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK    = PDU_DBUS_DEF_MASK,
    parameter int unsigned             TIMEOUT_CYC = 16
) (
    input logic              clk,
    input logic              rstn,
    pdu_dbus_bridge_if.slave bus
);

    localparam int unsigned IDX_W = pdu_idx_w(N_SLV);

    pdu_state_t        state_q, state_d;

    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic [ADDR_W-1:0] dec_base;

    logic              we_q;
    logic [IDX_W-1:0]  idx_q;
    logic [ADDR_W-1:0] off_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic [N_SLV-1:0]  sel_oh;
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;
    logic              timeout;

    pdu_dbus_decode #(
        .N_SLV    (N_SLV),
        .ADDR_W   (ADDR_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .addr (bus.h_addr),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    always_comb begin
        dec_base = '0;
        for (int unsigned k = 0; k < N_SLV; k++) begin
            if (dec_idx == IDX_W'(k)) dec_base = SLV_BASE[k*ADDR_W +: ADDR_W];
        end
    end

    // Only the latched slave's ready/rdata are looked at; others are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int unsigned k = 0; k < N_SLV; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_ready = bus.s_ready[k];
                sel_rdata = bus.s_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_oh = N_SLV'(1) << idx_q;

`ifdef PDU_DBUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;

    // Counts completed ACCESS cycles; zero on the first ACCESS cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                    cnt_q <= '0;
        else if (state_q != ST_ACCESS) cnt_q <= '0;
        else                          cnt_q <= cnt_q + 1'b1;
    end

    assign timeout = (state_q == ST_ACCESS) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        bus.s_sel  = '0;
        bus.s_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.h_req) state_d = dec_hit ? ST_ACCESS : ST_RESP;
            end
            ST_ACCESS: begin
                bus.s_sel = sel_oh;
                bus.s_we  = we_q;
                if (sel_ready || timeout) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Response registers change only on entry to RESP so they hold between
    // responses; the slave offset is computed once at request time.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_q    <= 1'b0;
            idx_q   <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.h_req) begin
                        we_q    <= bus.h_we;
                        wdata_q <= bus.h_wdata;
                        idx_q   <= dec_idx;
                        off_q   <= dec_hit ? (bus.h_addr - dec_base) : '0;
                        if (!dec_hit) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (sel_ready) begin
                        rdata_q <= we_q ? '0 : sel_rdata;
                        err_q   <= 1'b0;
                    end else if (timeout) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.h_busy  = (state_q != ST_IDLE);
    assign bus.h_ack   = (state_q == ST_RESP);
    assign bus.h_err   = err_q;
    assign bus.h_rdata = rdata_q;
    assign bus.s_addr  = off_q;
    assign bus.s_wdata = wdata_q;

endmodule

// File: tb/tb_pdu_dbus_bridge.sv
// ----------------------------------------------------------------------------
// tb_pdu_dbus_bridge
// Self-checking bench for pdu_dbus_bridge with the default three-slave map
// and TIMEOUT_CYC = 4. Honours PDU_DBUS_TIMEOUT_EN when defined.
// ----------------------------------------------------------------------------
module tb_pdu_dbus_bridge;

    localparam int unsigned N_SLV       = 3;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned TIMEOUT_CYC = 4;
`ifdef PDU_DBUS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    int checks = 0;
    int errors = 0;

    // Last delivered response; must persist until the next one.
    logic              hold_err;
    logic [DATA_W-1:0] hold_rdata;

    // Memory map as the host sees it (index 0 first).
    logic [ADDR_W-1:0] map_base [N_SLV] = '{32'h0000_4000, 32'h0000_8000, 32'h0000_8100};
    logic [ADDR_W-1:0] map_mask [N_SLV] = '{32'hFFFF_C000, 32'hFFFF_FF00, 32'hFFFF_FF00};

    pdu_dbus_bridge_if #(.N_SLV(N_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    pdu_dbus_bridge #(
        .N_SLV       (N_SLV),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic int ref_decode(input logic [ADDR_W-1:0] a);
        for (int k = 0; k < int'(N_SLV); k++)
            if ((a & map_mask[k]) == map_base[k]) return k;
        return -1;
    endfunction

    // One host transfer, starting just after a rising edge with the bridge
    // idle (cycle 0 = request cycle). rdy_cyc is the ACCESS cycle number
    // (1-based) in which the selected slave raises s_ready.
    task automatic xfer(input string name, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input int rdy_cyc,
                        input logic [DATA_W-1:0] rdval, input bit hold_req);
        int                k;
        int                ack_cyc;
        logic              exp_err;
        logic [DATA_W-1:0] exp_rdata;
        logic [N_SLV-1:0]  exp_oh;
        logic [N_SLV-1:0]  exp_sel;
        logic [ADDR_W-1:0] exp_off;
        logic [5:0]        exp_ctl;
        logic [5:0]        got_ctl;
        logic              exp_e;
        logic [DATA_W-1:0] exp_d;
        bit                in_acc;

        k = ref_decode(addr);
        if (k < 0) begin
            ack_cyc   = 1;
            exp_err   = 1'b1;
            exp_rdata = '0;
            exp_oh    = '0;
            exp_off   = '0;
        end else begin
            exp_oh  = N_SLV'(1) << k;
            exp_off = addr - map_base[k];
            if (TMO_EN && rdy_cyc > int'(TIMEOUT_CYC)) begin
                ack_cyc   = int'(TIMEOUT_CYC) + 1;
                exp_err   = 1'b1;
                exp_rdata = '0;
            end else begin
                ack_cyc   = rdy_cyc + 1;
                exp_err   = 1'b0;
                exp_rdata = we ? '0 : rdval;
            end
        end

        for (int c = 0; c <= ack_cyc; c++) begin
            if (c == 0) begin
                bus.h_req   = 1'b1;
                bus.h_we    = we;
                bus.h_addr  = addr;
                bus.h_wdata = wdata;
            end else begin
                bus.h_req   = hold_req;
                bus.h_we    = 1'($urandom);
                bus.h_addr  = ADDR_W'($urandom);
                bus.h_wdata = DATA_W'($urandom);
            end
            bus.s_ready = N_SLV'($urandom);
            for (int j = 0; j < int'(N_SLV); j++) bus.s_rdata[j*DATA_W +: DATA_W] = DATA_W'($urandom);
            if (k >= 0) begin
                bus.s_ready[k] = (c == rdy_cyc);
                bus.s_rdata[k*DATA_W +: DATA_W] = rdval;
            end

            @(negedge clk);
            in_acc  = (k >= 0) && (c >= 1) && (c < ack_cyc);
            exp_sel = in_acc ? exp_oh : {N_SLV{1'b0}};
            exp_ctl = {(c >= 1), (c == ack_cyc), exp_sel, (in_acc && we)};
            got_ctl = {bus.h_busy, bus.h_ack, bus.s_sel, bus.s_we};
            checks++;
            if (got_ctl !== exp_ctl) begin
                errors++;
                $display("FAIL %s c%0d busy/ack/sel/we: got %b expected %b", name, c, got_ctl, exp_ctl);
            end
            exp_e = (c == ack_cyc) ? exp_err   : hold_err;
            exp_d = (c == ack_cyc) ? exp_rdata : hold_rdata;
            checks++;
            if ({bus.h_err, bus.h_rdata} !== {exp_e, exp_d}) begin
                errors++;
                $display("FAIL %s c%0d err/rdata: got %b/%h expected %b/%h",
                         name, c, bus.h_err, bus.h_rdata, exp_e, exp_d);
            end
            if (in_acc) begin
                checks++;
                if ({bus.s_addr, bus.s_wdata} !== {exp_off, wdata}) begin
                    errors++;
                    $display("FAIL %s c%0d s_addr/s_wdata: got %h/%h expected %h/%h",
                             name, c, bus.s_addr, bus.s_wdata, exp_off, wdata);
                end
            end
            if (c < ack_cyc) begin
                @(posedge clk);
                #1;
            end
        end
        hold_err   = exp_err;
        hold_rdata = exp_rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.h_req   = 1'b0;
            bus.h_addr  = ADDR_W'($urandom);
            bus.s_ready = N_SLV'($urandom);
            @(negedge clk);
            checks++;
            if ({bus.h_busy, bus.h_ack, bus.s_sel, bus.s_we, bus.h_err, bus.h_rdata} !==
                {1'b0, 1'b0, {N_SLV{1'b0}}, 1'b0, hold_err, hold_rdata}) begin
                errors++;
                $display("FAIL idle busy/ack/sel/we/err/rdata: got %b%b%b%b %b %h expected 00%b0 %b %h",
                         bus.h_busy, bus.h_ack, bus.s_sel, bus.s_we, bus.h_err, bus.h_rdata,
                         {N_SLV{1'b0}}, hold_err, hold_rdata);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({bus.h_busy, bus.h_ack, bus.h_err, bus.s_sel, bus.s_we} !== '0 ||
            bus.h_rdata !== '0 || bus.s_addr !== '0 || bus.s_wdata !== '0) begin
            errors++;
            $display("FAIL %s outputs: got busy%b ack%b err%b sel%b we%b rdata%h addr%h wdata%h expected all zero",
                     name, bus.h_busy, bus.h_ack, bus.h_err, bus.s_sel, bus.s_we,
                     bus.h_rdata, bus.s_addr, bus.s_wdata);
        end
    endtask

    // Reset state, then the very first cycle after release carries a request.
    task automatic test_reset();
        rstn        = 1'b0;
        bus.h_req   = 1'b1;
        bus.h_we    = 1'b1;
        bus.h_addr  = 32'h0000_4010;
        bus.h_wdata = 32'h1234_5678;
        bus.s_ready = '1;
        bus.s_rdata = '1;
        hold_err    = 1'b0;
        hold_rdata  = '0;
        repeat (2) begin
            @(negedge clk);
            check_all_zero("reset");
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        xfer("first_write", 1'b1, 32'h0000_4010, 32'h1234_5678, 1, 32'h0, 1'b0);
    endtask

    task automatic test_directed();
        idle_cycles(1);
        xfer("read_8104", 1'b0, 32'h0000_8104, 32'h0, 3, 32'hCAFE_F00D, 1'b0);
        xfer("unmapped_9000", 1'b0, 32'h0000_9000, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
        xfer("stall_8000", 1'b0, 32'h0000_8000, 32'h0, 10, 32'h0BAD_CAFE, 1'b0);
        xfer("edge_7fff", 1'b0, 32'h0000_7FFF, 32'h0, 2, 32'h1111_2222, 1'b0);
        xfer("edge_80ff", 1'b1, 32'h0000_80FF, 32'hA5A5_5A5A, 1, 32'h3333_4444, 1'b0);
        xfer("edge_3fff", 1'b1, 32'h0000_3FFF, 32'h5555_6666, 1, 32'h0, 1'b0);
        xfer("edge_81ff", 1'b0, 32'h0000_81FF, 32'h0, 1, 32'h7777_8888, 1'b0);
        xfer("edge_8200", 1'b0, 32'h0000_8200, 32'h0, 1, 32'h9999_AAAA, 1'b0);
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a;
        int                pick;
        for (int i = 0; i < 40; i++) begin
            pick = int'($urandom_range(0, 3));
            if (pick < int'(N_SLV)) a = map_base[pick] | (ADDR_W'($urandom) & ~map_mask[pick]);
            else                    a = ADDR_W'($urandom) & 32'h0000_FFFF;
            xfer("rand", 1'($urandom), a, DATA_W'($urandom), int'($urandom_range(1, 6)),
                 DATA_W'($urandom), 1'b0);
            idle_cycles(int'($urandom_range(0, 2)));
        end
    endtask

    // Request held high: each new access begins in the cycle after h_ack.
    task automatic test_back_to_back();
        xfer("b2b_0", 1'b0, 32'h0000_8108, 32'h0, 2, 32'h0102_0304, 1'b1);
        xfer("b2b_1", 1'b1, 32'h0000_4100, 32'hFEED_BEEF, 1, 32'h0, 1'b1);
        xfer("b2b_2", 1'b0, 32'h0000_A000, 32'h0, 1, 32'h0, 1'b1);
        xfer("b2b_3", 1'b0, 32'h0000_8044, 32'h0, 3, 32'h5566_7788, 1'b0);
        idle_cycles(2);
    endtask

    task automatic test_reset_mid();
        xfer("pre_reset_err", 1'b0, 32'h0000_0010, 32'h0, 1, 32'h0, 1'b0);
        bus.h_req   = 1'b1;
        bus.h_we    = 1'b1;
        bus.h_addr  = 32'h0000_8020;
        bus.h_wdata = 32'h1357_9BDF;
        bus.s_ready = '0;
        @(posedge clk);
        #1;
        bus.h_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.h_busy, bus.s_sel, bus.s_we, bus.s_addr} !== {1'b1, 3'b010, 1'b1, 32'h0000_0020}) begin
            errors++;
            $display("FAIL mid_access busy/sel/we/addr: got %b %b %b %h expected 1 010 1 00000020",
                     bus.h_busy, bus.s_sel, bus.s_we, bus.s_addr);
        end
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        rstn       = 1'b1;
        hold_err   = 1'b0;
        hold_rdata = '0;
        xfer("post_reset", 1'b0, 32'h0000_4004, 32'h0, 2, 32'h2468_ACE0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
